// File: rtl/raptor64_bf_pkg.sv
// Shared definitions for the Raptor64 bitfield unit: op codes and the field-mask rule.
package raptor64_bf_pkg;

   localparam logic [2:0] BF_INS  = 3'd0;
   localparam logic [2:0] BF_SET  = 3'd1;
   localparam logic [2:0] BF_CLR  = 3'd2;
   localparam logic [2:0] BF_CHG  = 3'd3;
   localparam logic [2:0] BF_EXTU = 3'd4;
   localparam logic [2:0] BF_EXTS = 3'd5;
   localparam logic [2:0] BF_CNT  = 3'd6;

   localparam int BF_MAXW = 128;

   typedef logic [2:0] bf_op_t;

   // One mask bit; the XOR form covers both the plain and the wrapped field.
   function automatic logic bf_mask_bit(input int unsigned n, input int unsigned mb,
                                        input int unsigned me);
      return (n >= mb) ^ (n <= me) ^ (me >= mb);
   endfunction

   function automatic logic [BF_MAXW-1:0] bf_mask(input int unsigned wid,
                                                  input int unsigned mb,
                                                  input int unsigned me);
      logic [BF_MAXW-1:0] m;
      m = '0;
      for (int unsigned n = 0; n < BF_MAXW; n++) begin
         m[n] = (n < wid) && bf_mask_bit(n, mb, me);
      end
      return m;
   endfunction

endpackage

// File: rtl/raptor64_bf_mask.sv
// Combinational field-mask generator; also used by the decoder to validate immediates.
module raptor64_bf_mask
   import raptor64_bf_pkg::*;
#(
   parameter int WID = 64,
   localparam int MBW = $clog2(WID)
) (
   input  logic [MBW-1:0] mb,
   input  logic [MBW-1:0] me,
   output logic [WID-1:0] mask
);

   always_comb begin
      mask = '0;
      for (int unsigned n = 0; n < WID; n++) begin
         mask[n] = bf_mask_bit(n, 32'(mb), 32'(me));
      end
   end

endmodule

// File: rtl/raptor64_bitfield_pipe.sv
// Two-stage pipelined bitfield unit with valid/ready handshakes and a pass-through tag.
// Optional popcount op (op 6) is built only when RAPTOR64_BFCNT_EN is defined.
module raptor64_bitfield_pipe
   import raptor64_bf_pkg::*;
#(
   parameter int WID  = 64,
   parameter int TAGW = 6,
   localparam int MBW = $clog2(WID)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [2:0]      op_i,
   input  logic [MBW-1:0]  mb_i,
   input  logic [MBW-1:0]  me_i,
   input  logic [WID-1:0]  a_i,
   input  logic [WID-1:0]  b_i,
   input  logic [TAGW-1:0] tag_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [WID-1:0]  res_o,
   output logic [TAGW-1:0] tag_o
);

   logic [WID-1:0]  maskIn;
   logic            s1Valid;
   bf_op_t          s1Op;
   logic [MBW-1:0]  s1Mb;
   logic [MBW-1:0]  s1Me;
   logic [WID-1:0]  s1A;
   logic [WID-1:0]  s1B;
   logic [TAGW-1:0] s1Tag;
   logic [WID-1:0]  s1Mask;
   logic [WID-1:0]  resNext;
   logic            s2Adv;
   logic            s1Adv;

   raptor64_bf_mask #(.WID(WID)) maskGen (
      .mb   (mb_i),
      .me   (me_i),
      .mask (maskIn)
   );

   // No skid buffer: a consumer stall reaches in_ready_o combinationally.
   assign s2Adv      = !out_valid_o || out_ready_i;
   assign s1Adv      = !s1Valid || s2Adv;
   assign in_ready_o = s1Adv;

`ifdef RAPTOR64_BFCNT_EN
   localparam int NSL  = (WID + 15) / 16;
   localparam int PADW = NSL * 16;
   localparam int CNTW = $clog2(WID) + 1;

   logic [PADW-1:0]       cntSrc;
   logic [NSL-1:0][4:0]   partNext;
   logic [NSL-1:0][4:0]   s1Part;
   logic [CNTW-1:0]       cntSum;

   // Per-16-bit-slice partial counts are taken in stage 1 so stage 2 only adds a few terms.
   always_comb begin
      cntSrc   = PADW'(a_i & maskIn);
      partNext = '0;
      for (int s = 0; s < NSL; s++) begin
         for (int k = 0; k < 16; k++) begin
            partNext[s] = partNext[s] + 5'(cntSrc[s*16+k]);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         s1Part <= '0;
      end else if (s1Adv && in_valid_i) begin
         s1Part <= partNext;
      end
   end

   always_comb begin
      cntSum = '0;
      for (int s = 0; s < NSL; s++) begin
         cntSum = cntSum + CNTW'(s1Part[s]);
      end
   end
`endif

   // Stage 1 capture: operands plus the mask, so stage 2 carries no mask-decode depth.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         s1Valid <= 1'b0;
         s1Op    <= '0;
         s1Mb    <= '0;
         s1Me    <= '0;
         s1A     <= '0;
         s1B     <= '0;
         s1Tag   <= '0;
         s1Mask  <= '0;
      end else if (s1Adv) begin
         s1Valid <= in_valid_i;
         if (in_valid_i) begin
            s1Op   <= op_i;
            s1Mb   <= mb_i;
            s1Me   <= me_i;
            s1A    <= a_i;
            s1B    <= b_i;
            s1Tag  <= tag_i;
            s1Mask <= maskIn;
         end
      end
   end

   logic [WID-1:0] extu;
   logic [MBW-1:0] signIdx;

   // EXTS only sign-extends a non-wrapped field; a wrapped field returns the EXTU value.
   always_comb begin
      extu    = (s1A & s1Mask) >> s1Mb;
      signIdx = s1Me - s1Mb;
      resNext = '0;
      case (s1Op)
         BF_INS:  resNext = ((s1A << s1Mb) & s1Mask) | (s1B & ~s1Mask);
         BF_SET:  resNext = s1A | s1Mask;
         BF_CLR:  resNext = s1A & ~s1Mask;
         BF_CHG:  resNext = s1A ^ s1Mask;
         BF_EXTU: resNext = extu;
         BF_EXTS: begin
            resNext = extu;
            if ((s1Me >= s1Mb) && extu[signIdx]) begin
               resNext = extu | ({WID{1'b1}} << signIdx);
            end
         end
`ifdef RAPTOR64_BFCNT_EN
         BF_CNT:  resNext = WID'(cntSum);
`endif
         default: resNext = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         out_valid_o <= 1'b0;
         res_o       <= '0;
         tag_o       <= '0;
      end else if (s2Adv) begin
         out_valid_o <= s1Valid;
         if (s1Valid) begin
            res_o <= resNext;
            tag_o <= s1Tag;
         end
      end
   end

endmodule

// File: tb/tb_raptor64_bitfield_pipe.sv
// Self-checking bench for raptor64_bitfield_pipe: directed cases plus random traffic
// scored against a per-bit reference model of the field operations.
module tb_raptor64_bitfield_pipe;

   localparam int WID  = 64;
   localparam int TAGW = 6;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [2:0]      op_i;
   logic [5:0]      mb_i;
   logic [5:0]      me_i;
   logic [WID-1:0]  a_i;
   logic [WID-1:0]  b_i;
   logic [TAGW-1:0] tag_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [WID-1:0]  res_o;
   logic [TAGW-1:0] tag_o;

   raptor64_bitfield_pipe #(.WID(WID), .TAGW(TAGW)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .op_i        (op_i),
      .mb_i        (mb_i),
      .me_i        (me_i),
      .a_i         (a_i),
      .b_i         (b_i),
      .tag_i       (tag_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .res_o       (res_o),
      .tag_o       (tag_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [WID-1:0]  res;
      logic [TAGW-1:0] tag;
   } expect_t;

   expect_t         expQ[$];
   logic [TAGW-1:0] obsTags[$];
   int              numChecks = 0;
   int              numFails  = 0;
   logic            prevStall = 1'b0;
   logic [WID-1:0]  stallRes;
   logic [TAGW-1:0] stallTag;

   localparam logic [WID-1:0] ONES = {WID{1'b1}};

   task automatic checkOutput(input string name, input logic [WID-1:0] got,
                              input logic [WID-1:0] want);
      numChecks++;
      if (got !== want) begin
         numFails++;
         $display("[TB] FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   function automatic logic inField(input int n, input int mb, input int me);
      if (mb <= me) return (n >= mb) && (n <= me);
      return (n >= mb) || (n <= me);
   endfunction

   // Reference result, bit by bit from the field definition.
   function automatic logic [WID-1:0] refRes(input logic [2:0] op, input int mb, input int me,
                                             input logic [WID-1:0] a, input logic [WID-1:0] b);
      logic [WID-1:0] r;
      int cnt;
      int w;
      r = '0;
      cnt = 0;
      for (int n = 0; n < WID; n++) begin
         case (op)
            3'd0: r[n] = inField(n, mb, me) ? ((n >= mb) ? a[n-mb] : 1'b0) : b[n];
            3'd1: r[n] = inField(n, mb, me) ? 1'b1 : a[n];
            3'd2: r[n] = inField(n, mb, me) ? 1'b0 : a[n];
            3'd3: r[n] = inField(n, mb, me) ? ~a[n] : a[n];
            3'd4, 3'd5: r[n] = ((n + mb) < WID) && inField(n + mb, mb, me) && a[n+mb];
            3'd6: if (inField(n, mb, me) && a[n]) cnt++;
            default: r[n] = 1'b0;
         endcase
      end
      if (op == 3'd5 && mb <= me) begin
         w = me - mb + 1;
         if (r[w-1]) begin
            for (int n = w; n < WID; n++) r[n] = 1'b1;
         end
      end
`ifdef RAPTOR64_BFCNT_EN
      if (op == 3'd6) r = WID'(cnt);
`endif
      return r;
   endfunction

   // One clock: score this cycle's transfers at the negedge, then advance to the next negedge.
   task automatic stepCycle();
      expect_t e;
      #1;
      if (!rst_i) begin
         expQ.delete();
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checkOutput("stall_valid", WID'(out_valid_o), 1);
            checkOutput("stall_res", res_o, stallRes);
            checkOutput("stall_tag", WID'(tag_o), WID'(stallTag));
         end
         if (out_valid_o && out_ready_i) begin
            obsTags.push_back(tag_o);
            if (expQ.size() == 0) begin
               checkOutput("spurious_valid", WID'(out_valid_o), 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("sb_res", res_o, e.res);
               checkOutput("sb_tag", WID'(tag_o), WID'(e.tag));
            end
         end
         prevStall = out_valid_o && !out_ready_i;
         stallRes  = res_o;
         stallTag  = tag_o;
         if (in_valid_i && in_ready_o) begin
            e.res = refRes(op_i, int'(mb_i), int'(me_i), a_i, b_i);
            e.tag = tag_i;
            expQ.push_back(e);
         end
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] op, input int mb, input int me,
                                input logic [WID-1:0] a, input logic [WID-1:0] b,
                                input logic [TAGW-1:0] tag, input logic rdy);
      in_valid_i  = v;
      op_i        = op;
      mb_i        = 6'(mb);
      me_i        = 6'(me);
      a_i         = a;
      b_i         = b;
      tag_i       = tag;
      out_ready_i = rdy;
      stepCycle();
   endtask

   task automatic runOne(input string name, input logic [2:0] op, input int mb, input int me,
                         input logic [WID-1:0] a, input logic [WID-1:0] b,
                         input logic [TAGW-1:0] tag, input logic [WID-1:0] want,
                         output int lat);
      applyStimulus(1'b1, op, mb, me, a, b, tag, 1'b1);
      lat = 1;
      while (!out_valid_o && lat < 10) begin
         applyStimulus(1'b0, 3'd0, 0, 0, '0, '0, '0, 1'b1);
         lat++;
      end
      checkOutput(name, res_o, want);
   endtask

   initial begin
      int lat;
      int sawValid;
      logic [WID-1:0] held;
      logic [WID-1:0] cntFull;
      logic [WID-1:0] cntWrap;

      rst_i = 1'b0;
      in_valid_i = 1'b0; op_i = '0; mb_i = '0; me_i = '0;
      a_i = '0; b_i = '0; tag_i = '0; out_ready_i = 1'b1;
      @(negedge clk_i);
      applyStimulus(1'b0, 3'd0, 0, 0, '0, '0, '0, 1'b1);
      applyStimulus(1'b0, 3'd0, 0, 0, '0, '0, '0, 1'b1);
      rst_i = 1'b1;
      #1;
      checkOutput("rst_valid", WID'(out_valid_o), 0);
      checkOutput("rst_res", res_o, 0);
      checkOutput("rst_tag", WID'(tag_o), 0);
      checkOutput("rst_inready", WID'(in_ready_o), 1);

      $display("[TB] directed operations");
      runOne("ins", 3'd0, 8, 15, 64'hAB, ONES, 6'd5, 64'hFFFF_FFFF_FFFF_ABFF, lat);
      checkOutput("ins_latency", WID'(lat), 2);
      checkOutput("ins_tag", WID'(tag_o), 5);
      runOne("extu", 3'd4, 8, 11, 64'h0F00, '0, 6'd6, 64'hF, lat);
      runOne("exts_neg", 3'd5, 8, 11, 64'h0F00, '0, 6'd7, ONES, lat);
      runOne("exts_pos", 3'd5, 8, 11, 64'h0700, '0, 6'd8, 64'h7, lat);
      runOne("set_wrap", 3'd1, 62, 1, '0, '0, 6'd9, 64'hC000_0000_0000_0003, lat);
      runOne("clr_wrap", 3'd2, 62, 1, ONES, '0, 6'd10, 64'h3FFF_FFFF_FFFF_FFFC, lat);
      runOne("single_bit", 3'd3, 63, 63, '0, '0, 6'd11, 64'h8000_0000_0000_0000, lat);
      runOne("op7", 3'd7, 0, 63, ONES, ONES, 6'd12, '0, lat);
`ifdef RAPTOR64_BFCNT_EN
      cntFull = 64'h40;
      cntWrap = 64'h4;
`else
      cntFull = '0;
      cntWrap = '0;
`endif
      runOne("cnt_full", 3'd6, 0, 63, ONES, '0, 6'd13, cntFull, lat);
      runOne("cnt_wrap", 3'd6, 62, 1, ONES, '0, 6'd14, cntWrap, lat);
      applyStimulus(1'b0, 3'd0, 0, 0, '0, '0, '0, 1'b1);

      $display("[TB] backpressure");
      applyStimulus(1'b1, 3'd1, 0, 7, '0, '0, 6'd1, 1'b0);
      applyStimulus(1'b1, 3'd1, 8, 15, '0, '0, 6'd2, 1'b0);
      checkOutput("bp_inready", WID'(in_ready_o), 0);
      held = res_o;
      applyStimulus(1'b1, 3'd1, 16, 23, '0, '0, 6'd3, 1'b0);
      applyStimulus(1'b1, 3'd1, 16, 23, '0, '0, 6'd3, 1'b0);
      checkOutput("bp_hold", res_o, held);
      checkOutput("bp_holdtag", WID'(tag_o), 1);
      obsTags.delete();
      applyStimulus(1'b1, 3'd1, 16, 23, '0, '0, 6'd3, 1'b1);
      applyStimulus(1'b0, 3'd0, 0, 0, '0, '0, '0, 1'b1);
      applyStimulus(1'b0, 3'd0, 0, 0, '0, '0, '0, 1'b1);
      checkOutput("bp_count", WID'(obsTags.size()), 3);
      for (int i = 0; i < 3; i++) begin
         checkOutput("bp_order", (i < obsTags.size()) ? WID'(obsTags[i]) : ONES, WID'(i + 1));
      end

      $display("[TB] reset mid-operation");
      applyStimulus(1'b1, 3'd1, 0, 3, '0, '0, 6'd20, 1'b1);
      applyStimulus(1'b1, 3'd1, 4, 7, '0, '0, 6'd21, 1'b1);
      rst_i = 1'b0;
      applyStimulus(1'b0, 3'd0, 0, 0, '0, '0, '0, 1'b1);
      rst_i = 1'b1;
      #1;
      checkOutput("mid_rst_valid", WID'(out_valid_o), 0);
      checkOutput("mid_rst_res", res_o, 0);
      checkOutput("mid_rst_tag", WID'(tag_o), 0);
      sawValid = 0;
      for (int i = 0; i < 4; i++) begin
         if (out_valid_o) sawValid++;
         applyStimulus(1'b0, 3'd0, 0, 0, '0, '0, '0, 1'b1);
      end
      checkOutput("no_stale", WID'(sawValid), 0);
      runOne("post_rst", 3'd0, 4, 11, 64'h5A, '0, 6'd22, 64'h5A0, lat);
      checkOutput("post_rst_latency", WID'(lat), 2);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom % 4) != 0, 3'($urandom % 8), int'($urandom % 64),
                       int'($urandom % 64), {$urandom, $urandom}, {$urandom, $urandom},
                       6'($urandom), ($urandom % 4) != 0);
      end
      for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
         applyStimulus(1'b0, 3'd0, 0, 0, '0, '0, '0, 1'b1);
      end
      checkOutput("drain_empty", WID'(expQ.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
